// File: rtl/id_pipe_stage.sv
// Instruction-decode stage of the MIPS pipeline: control decode, 32-entry register file,
// operand/immediate formation, load-use stall insertion and the ID/EX pipeline register.
module id_pipe_stage #(
    parameter int DATA_W    = 32,
    parameter int BYPASS_EN = 1,
    parameter int HAZARD_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_valid,
    input  logic [31:0]       if_instruction,
    input  logic [DATA_W-1:0] if_pc_plus_4,
    output logic              id_ready,
    input  logic              interrupt,
    input  logic              flush,
    input  logic              wb_reg_write,
    input  logic [4:0]        wb_write_addr,
    input  logic [DATA_W-1:0] wb_write_data,
    input  logic              ex_ready,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_databus_a,
    output logic [DATA_W-1:0] ex_databus_b,
    output logic [DATA_W-1:0] ex_databus_c,
    output logic [31:0]       ex_control,
    output logic [4:0]        ex_reg_addr,
    output logic [DATA_W-1:0] ex_pc_plus_4,
    output logic [31:0]       ex_instruction,
    output logic [15:0]       stall_count
);

    // Handshake: an IF word transfers into ID on a rising edge where if_valid & id_ready;
    // the ID/EX register transfers to EX on a rising edge where ex_valid & ex_ready.

    localparam int CTL_MEMREAD = 11;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rsAddr;
    logic [4:0]  rtAddr;
    logic [4:0]  rdAddr;
    logic [4:0]  shamt;
    logic [15:0] imm;

    assign opcode = if_instruction[31:26];
    assign rsAddr = if_instruction[25:21];
    assign rtAddr = if_instruction[20:16];
    assign rdAddr = if_instruction[15:11];
    assign shamt  = if_instruction[10:6];
    assign funct  = if_instruction[5:0];
    assign imm    = if_instruction[15:0];

    logic [2:0]  pcSrc;
    logic        regWrite;
    logic [1:0]  regDst;
    logic        memRead;
    logic        memWrite;
    logic [1:0]  memToReg;
    logic        aluSrc1;
    logic        aluSrc2;
    logic        extOp;
    logic        luOp;
    logic        exception;
    logic [31:0] ctrlWord;

    always_comb begin
        pcSrc     = 3'd0;
        regWrite  = 1'b0;
        regDst    = 2'b00;
        memRead   = 1'b0;
        memWrite  = 1'b0;
        memToReg  = 2'b00;
        aluSrc1   = 1'b0;
        aluSrc2   = 1'b0;
        extOp     = 1'b1;
        luOp      = 1'b0;
        exception = 1'b0;
        case (opcode)
            6'h00: begin
                regWrite = 1'b1;
                regDst   = 2'b01;
                case (funct)
                    6'h00, 6'h02, 6'h03: aluSrc1 = 1'b1;
                    6'h08: begin
                        pcSrc    = 3'd3;
                        regWrite = 1'b0;
                    end
                    6'h09: begin
                        pcSrc    = 3'd3;
                        memToReg = 2'b10;
                    end
                    default: ;
                endcase
            end
            6'h02: pcSrc = 3'd2;
            6'h03: begin
                pcSrc    = 3'd2;
                regWrite = 1'b1;
                regDst   = 2'b10;
                memToReg = 2'b10;
            end
            6'h04, 6'h05: pcSrc = 3'd1;
            6'h08, 6'h09, 6'h0a, 6'h0b: begin
                regWrite = 1'b1;
                aluSrc2  = 1'b1;
            end
            6'h0c, 6'h0d, 6'h0e: begin
                regWrite = 1'b1;
                aluSrc2  = 1'b1;
                extOp    = 1'b0;
            end
            6'h0f: begin
                regWrite = 1'b1;
                aluSrc2  = 1'b1;
                luOp     = 1'b1;
            end
            6'h23: begin
                regWrite = 1'b1;
                aluSrc2  = 1'b1;
                memRead  = 1'b1;
                memToReg = 2'b01;
            end
            6'h2b: begin
                aluSrc2  = 1'b1;
                memWrite = 1'b1;
            end
            default: begin
                // Unknown opcode traps and saves the return address in $26.
                exception = 1'b1;
                pcSrc     = 3'd5;
                regWrite  = 1'b1;
                regDst    = 2'b11;
                memToReg  = 2'b10;
            end
        endcase
        if (interrupt) begin
            pcSrc     = 3'd4;
            regWrite  = 1'b1;
            regDst    = 2'b11;
            memRead   = 1'b0;
            memWrite  = 1'b0;
            memToReg  = 2'b10;
            exception = 1'b0;
        end
        ctrlWord        = '0;
        ctrlWord[2:0]   = pcSrc;
        ctrlWord[8]     = regWrite;
        ctrlWord[10:9]  = regDst;
        ctrlWord[11]    = memRead;
        ctrlWord[12]    = memWrite;
        ctrlWord[14:13] = memToReg;
        ctrlWord[15]    = aluSrc1;
        ctrlWord[16]    = aluSrc2;
        ctrlWord[17]    = extOp;
        ctrlWord[18]    = luOp;
        ctrlWord[22]    = exception;
    end

    logic [DATA_W-1:0] regFile [32];
    logic              wbActive;

    assign wbActive = wb_reg_write && (wb_write_addr != 5'd0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regFile[i] <= '0;
            end
        end else if (wbActive) begin
            regFile[wb_write_addr] <= wb_write_data;
        end
    end

    logic [DATA_W-1:0] rsData;
    logic [DATA_W-1:0] rtData;

    always_comb begin
        rsData = regFile[rsAddr];
        rtData = regFile[rtAddr];
        if (BYPASS_EN != 0 && wbActive && wb_write_addr == rsAddr) begin
            rsData = wb_write_data;
        end
        if (BYPASS_EN != 0 && wbActive && wb_write_addr == rtAddr) begin
            rtData = wb_write_data;
        end
    end

    logic [DATA_W-1:0] operandA;
    logic [DATA_W-1:0] immExt;
    logic [4:0]        destAddr;

    always_comb begin
        operandA = aluSrc1 ? DATA_W'(shamt) : rsData;
        if (luOp) begin
            immExt = DATA_W'($signed({imm, 16'h0000}));
        end else if (extOp) begin
            immExt = DATA_W'($signed(imm));
        end else begin
            immExt = DATA_W'(imm);
        end
        case (regDst)
            2'b00:   destAddr = rtAddr;
            2'b01:   destAddr = rdAddr;
            2'b10:   destAddr = 5'd31;
            default: destAddr = 5'd26;
        endcase
    end

    logic adv;
    logic hazard;

    assign adv    = ex_ready || !ex_valid;
    assign hazard = (HAZARD_EN != 0) && if_valid && ex_valid && ex_control[CTL_MEMREAD]
                    && (ex_reg_addr != 5'd0)
                    && (ex_reg_addr == rsAddr || ex_reg_addr == rtAddr);
    assign id_ready = reset && (flush || (adv && !hazard));

    always_ff @(posedge clk) begin
        if (!reset) begin
            ex_valid       <= 1'b0;
            ex_databus_a   <= '0;
            ex_databus_b   <= '0;
            ex_databus_c   <= '0;
            ex_control     <= '0;
            ex_reg_addr    <= '0;
            ex_pc_plus_4   <= '0;
            ex_instruction <= '0;
            stall_count    <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (adv) begin
            if (if_valid && !hazard) begin
                ex_valid       <= 1'b1;
                ex_databus_a   <= operandA;
                ex_databus_b   <= rtData;
                ex_databus_c   <= immExt;
                ex_control     <= ctrlWord;
                ex_reg_addr    <= destAddr;
                ex_pc_plus_4   <= if_pc_plus_4;
                ex_instruction <= if_instruction;
            end else begin
                ex_valid <= 1'b0;
                if (hazard && stall_count != 16'hFFFF) begin
                    stall_count <= stall_count + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_id_pipe_stage.sv
// Bench for id_pipe_stage: a default instance plus a DATA_W=64, BYPASS_EN=0 instance share
// the stimulus; a queue-based scoreboard checks every word handed to EX.
module tb_id_pipe_stage;

    localparam logic [31:0] CTL_MASK = 32'h0046_8F07;

    logic        clk = 1'b0;
    logic        reset;
    logic        ifValid;
    logic [31:0] ifInstruction;
    logic [63:0] ifPc;
    logic        interrupt;
    logic        flush;
    logic        wbRegWrite;
    logic [4:0]  wbAddr;
    logic [63:0] wbData;
    logic        exReady;

    logic        idReady, exValid;
    logic [31:0] exA, exB, exC, exControl, exPc, exInstr;
    logic [4:0]  exDst;
    logic [15:0] stallCount;

    logic        idReady2, exValid2;
    logic [63:0] exA2, exB2, exC2, exPc2;
    logic [31:0] exControl2, exInstr2;
    logic [4:0]  exDst2;
    logic [15:0] stallCount2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_pipe_stage dut (
        .clk(clk), .reset(reset), .if_valid(ifValid), .if_instruction(ifInstruction),
        .if_pc_plus_4(ifPc[31:0]), .id_ready(idReady), .interrupt(interrupt), .flush(flush),
        .wb_reg_write(wbRegWrite), .wb_write_addr(wbAddr), .wb_write_data(wbData[31:0]),
        .ex_ready(exReady), .ex_valid(exValid), .ex_databus_a(exA), .ex_databus_b(exB),
        .ex_databus_c(exC), .ex_control(exControl), .ex_reg_addr(exDst),
        .ex_pc_plus_4(exPc), .ex_instruction(exInstr), .stall_count(stallCount)
    );

    id_pipe_stage #(.DATA_W(64), .BYPASS_EN(0), .HAZARD_EN(1)) dut2 (
        .clk(clk), .reset(reset), .if_valid(ifValid), .if_instruction(ifInstruction),
        .if_pc_plus_4(ifPc), .id_ready(idReady2), .interrupt(interrupt), .flush(flush),
        .wb_reg_write(wbRegWrite), .wb_write_addr(wbAddr), .wb_write_data(wbData),
        .ex_ready(exReady), .ex_valid(exValid2), .ex_databus_a(exA2), .ex_databus_b(exB2),
        .ex_databus_c(exC2), .ex_control(exControl2), .ex_reg_addr(exDst2),
        .ex_pc_plus_4(exPc2), .ex_instruction(exInstr2), .stall_count(stallCount2)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [63:0] a32, b32, c32, a64, b64, c64;
        logic [31:0] ctl;
        logic [4:0]  dst;
    } expT;

    expT expQ[$];
    expT me;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ctlWord(input logic [2:0] pcs, input logic rw,
                                            input logic [1:0] rd, input logic mr,
                                            input logic as1, input logic ext,
                                            input logic lu, input logic exc);
        ctlWord        = '0;
        ctlWord[2:0]   = pcs;
        ctlWord[8]     = rw;
        ctlWord[10:9]  = rd;
        ctlWord[11]    = mr;
        ctlWord[15]    = as1;
        ctlWord[17]    = ext;
        ctlWord[18]    = lu;
        ctlWord[22]    = exc;
    endfunction

    // Monitor: every word EX takes must match the head of the expected queue.
    always @(negedge clk) begin
        if (reset && exValid && exReady) begin
            if (expQ.size() == 0) begin
                chk("unexpected_output", 64'd1, 64'd0);
            end else begin
                me = expQ.pop_front();
                chk("a32", exA, me.a32);
                chk("b32", exB, me.b32);
                chk("c32", exC, me.c32);
                chk("ctl32", exControl & CTL_MASK, me.ctl);
                chk("dst32", exDst, me.dst);
                chk("pc32", exPc, me.pc[31:0]);
                chk("instr32", exInstr, me.instr);
                chk("valid64", exValid2, 1'b1);
                chk("a64", exA2, me.a64);
                chk("b64", exB2, me.b64);
                chk("c64", exC2, me.c64);
                chk("ctl64", exControl2 & CTL_MASK, me.ctl);
                chk("dst64", exDst2, me.dst);
                chk("pc64", exPc2, me.pc);
                chk("instr64", exInstr2, me.instr);
            end
        end
    end

    task automatic idle(input int n);
        ifValid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wbWrite(input logic [4:0] addr, input logic [63:0] data);
        wbRegWrite = 1'b1;
        wbAddr     = addr;
        wbData     = data;
        @(posedge clk);
        #1;
        wbRegWrite = 1'b0;
    endtask

    task automatic sendInstr(input logic [31:0] ins, input logic [63:0] pc,
                             output int waited, output logic evAtAccept);
        ifValid       = 1'b1;
        ifInstruction = ins;
        ifPc          = pc;
        waited        = 0;
        @(negedge clk);
        while (!idReady && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        evAtAccept = exValid;
        if (!idReady) chk("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        ifValid = 1'b0;
    endtask

    task automatic issue(input logic [31:0] ins, input logic [63:0] pc,
                         input logic [63:0] a32, input logic [63:0] b32, input logic [63:0] c32,
                         input logic [63:0] a64, input logic [63:0] b64, input logic [63:0] c64,
                         input logic [31:0] ctl, input logic [4:0] dst,
                         output int waited, output logic ev);
        expT e;
        e.instr = ins; e.pc = pc;
        e.a32 = a32; e.b32 = b32; e.c32 = c32;
        e.a64 = a64; e.b64 = b64; e.c64 = c64;
        e.ctl = ctl; e.dst = dst;
        expQ.push_back(e);
        sendInstr(ins, pc, waited, ev);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   w;
        logic ev;
        reset = 1'b0; interrupt = 1'b0; flush = 1'b0; exReady = 1'b1;
        // Live instruction and a writeback during reset must both be ignored.
        ifValid = 1'b1; ifInstruction = 32'h3C01_8000; ifPc = 64'h10;
        wbRegWrite = 1'b1; wbAddr = 5'd9; wbData = 64'hDEAD;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ex_valid", exValid, 1'b0);
        chk("rst_stall", stallCount, 16'd0);
        chk("rst_id_ready", idReady, 1'b0);
        chk("rst_a", exA, 32'd0);
        chk("rst_c", exC, 32'd0);
        chk("rst_ctl", exControl, 32'd0);
        chk("rst_dst", exDst, 5'd0);
        chk("rst_pc", exPc, 32'd0);
        chk("rst_instr", exInstr, 32'd0);
        chk("rst_ex_valid64", exValid2, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1; ifValid = 1'b0; wbRegWrite = 1'b0;

        // Same-cycle write of r5 while decoding addu r3,r5,r0: bypass vs. pre-write value.
        wbRegWrite = 1'b1; wbAddr = 5'd5; wbData = 64'h1234;
        issue(32'h00A0_1821, 64'hA000_0000_0000_1004, 64'h1234, 0, 64'h1821,
              0, 0, 64'h1821, ctlWord(3'd0, 1, 2'b01, 0, 0, 1, 0, 0), 5'd3, w, ev);
        chk("bypass_wait", w, 0);
        wbRegWrite = 1'b0;
        // sll r6,r5,4
        issue(32'h0005_3100, 64'hA000_0000_0000_1008, 64'd4, 64'h1234, 64'h3100,
              64'd4, 64'h1234, 64'h3100, ctlWord(3'd0, 1, 2'b01, 0, 1, 1, 0, 0), 5'd6, w, ev);
        // addiu r7,r5,-1
        issue(32'h24A7_FFFF, 64'hA000_0000_0000_100C, 64'h1234, 0, 64'hFFFF_FFFF,
              64'h1234, 0, 64'hFFFF_FFFF_FFFF_FFFF, ctlWord(3'd0, 1, 2'b00, 0, 0, 1, 0, 0),
              5'd7, w, ev);
        // andi r8,r5,0x8000
        issue(32'h30A8_8000, 64'hA000_0000_0000_1010, 64'h1234, 0, 64'h8000,
              64'h1234, 0, 64'h8000, ctlWord(3'd0, 1, 2'b00, 0, 0, 0, 0, 0), 5'd8, w, ev);
        // lui r1,0x8000
        issue(32'h3C01_8000, 64'hA000_0000_0000_1014, 0, 0, 64'h8000_0000,
              0, 0, 64'hFFFF_FFFF_8000_0000, ctlWord(3'd0, 1, 2'b00, 0, 0, 1, 1, 0),
              5'd1, w, ev);
        // jal 0x10
        issue(32'h0C00_0010, 64'hA000_0000_0000_1018, 0, 0, 64'h10,
              0, 0, 64'h10, ctlWord(3'd2, 1, 2'b10, 0, 0, 1, 0, 0), 5'd31, w, ev);
        // Illegal opcode 0x3f
        issue(32'hFC00_0000, 64'hA000_0000_0000_101C, 0, 0, 0,
              0, 0, 0, ctlWord(3'd5, 1, 2'b11, 0, 0, 1, 0, 1), 5'd26, w, ev);
        idle(3);

        // Load-use: lw r2,0(r1) then addu r4,r2,r2.
        wbWrite(5'd1, 64'h100);
        wbWrite(5'd2, 64'h55);
        idle(1);
        issue(32'h8C22_0000, 64'hA000_0000_0000_2004, 64'h100, 64'h55, 0,
              64'h100, 64'h55, 0, ctlWord(3'd0, 1, 2'b00, 1, 0, 1, 0, 0), 5'd2, w, ev);
        issue(32'h0042_2021, 64'hA000_0000_0000_2008, 64'h55, 64'h55, 64'h2021,
              64'h55, 64'h55, 64'h2021, ctlWord(3'd0, 1, 2'b01, 0, 0, 1, 0, 0), 5'd4, w, ev);
        chk("loaduse_wait", w, 1);
        chk("loaduse_bubble", ev, 1'b0);
        idle(3);
        chk("loaduse_stall", stallCount, 16'd1);
        chk("loaduse_stall64", stallCount2, 16'd1);

        // EX back-pressure for 3 cycles: ori r9,r5,0xff held; r9 never took the reset-time write.
        exReady = 1'b0;
        issue(32'h34A9_00FF, 64'hA000_0000_0000_3004, 64'h1234, 0, 64'hFF,
              64'h1234, 0, 64'hFF, ctlWord(3'd0, 1, 2'b00, 0, 0, 0, 0, 0), 5'd9, w, ev);
        ifValid = 1'b1; ifInstruction = 32'h00A0_1821; ifPc = 64'hA000_0000_0000_3008;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_id_ready", idReady, 1'b0);
            chk("hold_valid", exValid, 1'b1);
            chk("hold_instr", exInstr, 32'h34A9_00FF);
            chk("hold_c", exC, 32'hFF);
        end
        @(posedge clk);
        #1;
        exReady = 1'b1;
        issue(32'h00A0_1821, 64'hA000_0000_0000_3008, 64'h1234, 0, 64'h1821,
              64'h1234, 0, 64'h1821, ctlWord(3'd0, 1, 2'b01, 0, 0, 1, 0, 0), 5'd3, w, ev);
        idle(2);

        // Flush while a load-use hazard is pending.
        issue(32'h8C22_0000, 64'hA000_0000_0000_4004, 64'h100, 64'h55, 0,
              64'h100, 64'h55, 0, ctlWord(3'd0, 1, 2'b00, 1, 0, 1, 0, 0), 5'd2, w, ev);
        ifValid = 1'b1; ifInstruction = 32'h0042_2021; ifPc = 64'hA000_0000_0000_4008;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_id_ready", idReady, 1'b1);
        @(posedge clk);
        #1;
        flush = 1'b0; ifValid = 1'b0;
        @(negedge clk);
        chk("flush_valid", exValid, 1'b0);
        chk("flush_stall", stallCount, 16'd1);
        idle(2);

        // Reset in the middle of a load-use stall.
        issue(32'h8C22_0000, 64'hA000_0000_0000_5004, 64'h100, 64'h55, 0,
              64'h100, 64'h55, 0, ctlWord(3'd0, 1, 2'b00, 1, 0, 1, 0, 0), 5'd2, w, ev);
        ifValid = 1'b1; ifInstruction = 32'h0042_2021; ifPc = 64'hA000_0000_0000_5008;
        @(negedge clk);
        chk("stall_id_ready", idReady, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0; ifValid = 1'b0;
        @(negedge clk);
        chk("prereset_stall", stallCount, 16'd2);
        chk("inreset_id_ready", idReady, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("midrst_valid", exValid, 1'b0);
        chk("midrst_stall", stallCount, 16'd0);
        chk("midrst_stall64", stallCount2, 16'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        issue(32'h00A0_1821, 64'hA000_0000_0000_6004, 0, 0, 64'h1821,
              0, 0, 64'h1821, ctlWord(3'd0, 1, 2'b01, 0, 0, 1, 0, 0), 5'd3, w, ev);
        idle(4);
        chk("queue_empty", expQ.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
